// File: rtl/conv_sequencer.sv
// conv_sequencer: feeds one complex sample at a time to an external convolver
// over an ap_ctrl_hs handshake, then presents the convolver result downstream.
// It also owns the coefficient bank that the convolver reads.
// Build macro CONV_SEQ_TIMEOUT_EN: adds timeout_err and abandons a convolution
// that has not completed within TIMEOUT_CYCLES cycles of START/WAIT.
module conv_sequencer #(
    parameter int DW             = 18,
    parameter int NTAP           = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic signed [DW-1:0]       s_real,
    input  logic signed [DW-1:0]       s_imag,
    output logic signed [DW-1:0]       x_real,
    output logic signed [DW-1:0]       x_imag,
    output logic                       conv_start,
    input  logic                       conv_ready,
    input  logic                       conv_done,
    input  logic signed [DW-1:0]       conv_real,
    input  logic signed [DW-1:0]       conv_imag,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic signed [DW-1:0]       m_real,
    output logic signed [DW-1:0]       m_imag,
    input  logic                       coef_we,
    input  logic [4:0]                 coef_addr,
    input  logic signed [DW-1:0]       coef_wr_real,
    input  logic signed [DW-1:0]       coef_wr_imag,
    output logic [NTAP-1:0][DW-1:0]    coef_real,
    output logic [NTAP-1:0][DW-1:0]    coef_imag,
    output logic                       busy
`ifdef CONV_SEQ_TIMEOUT_EN
    ,
    output logic                       timeout_err
`endif
);

    typedef enum logic [1:0] {IDLE, START, WAIT, OUT} state_t;

    // Elaboration-time sanity checks on the configuration.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end
    if (NTAP > 32 || NTAP < 1) begin : g_bad_ntap
        $error("NTAP must be between 1 and 32 (5-bit coef_addr)");
    end

    state_t                   state_q;
    logic                     s_ready_q;
    logic                     conv_start_q;
    logic                     m_valid_q;
    logic                     busy_q;
    logic signed [DW-1:0]     x_real_q, x_imag_q;
    logic signed [DW-1:0]     m_real_q, m_imag_q;
    logic [NTAP-1:0][DW-1:0]  coef_real_q, coef_imag_q;
    logic                     done_evt;

`ifdef CONV_SEQ_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TCNT_W-1:0]        tcnt_q;
    logic                     terr_q;
    assign timeout_err = terr_q;
`endif

    // A result is available: in START it must coincide with conv_ready,
    // in WAIT conv_done alone is enough.
    assign done_evt = conv_done && (conv_ready || (state_q == WAIT));

    assign s_ready    = s_ready_q;
    assign conv_start = conv_start_q;
    assign m_valid    = m_valid_q;
    assign busy       = busy_q;
    assign x_real     = x_real_q;
    assign x_imag     = x_imag_q;
    assign m_real     = m_real_q;
    assign m_imag     = m_imag_q;
    assign coef_real  = coef_real_q;
    assign coef_imag  = coef_imag_q;

    // Sequencer FSM with registered handshake outputs, sample/result holding
    // registers and the coefficient bank (written only while idle).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            s_ready_q    <= 1'b1;
            conv_start_q <= 1'b0;
            m_valid_q    <= 1'b0;
            busy_q       <= 1'b0;
            x_real_q     <= '0;
            x_imag_q     <= '0;
            m_real_q     <= '0;
            m_imag_q     <= '0;
            coef_real_q  <= '0;
            coef_imag_q  <= '0;
`ifdef CONV_SEQ_TIMEOUT_EN
            tcnt_q       <= '0;
            terr_q       <= 1'b0;
`endif
        end else begin
`ifdef CONV_SEQ_TIMEOUT_EN
            terr_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    // The bank write lands at this edge, so a sample accepted
                    // in the same cycle already sees the new coefficient.
                    if (coef_we) begin
                        coef_real_q[coef_addr] <= coef_wr_real;
                        coef_imag_q[coef_addr] <= coef_wr_imag;
                    end
                    if (s_valid) begin
                        x_real_q     <= s_real;
                        x_imag_q     <= s_imag;
                        state_q      <= START;
                        s_ready_q    <= 1'b0;
                        conv_start_q <= 1'b1;
                        busy_q       <= 1'b1;
`ifdef CONV_SEQ_TIMEOUT_EN
                        tcnt_q       <= '0;
`endif
                    end
                end
                START: begin
                    if (done_evt) begin
                        m_real_q     <= conv_real;
                        m_imag_q     <= conv_imag;
                        state_q      <= OUT;
                        conv_start_q <= 1'b0;
                        m_valid_q    <= 1'b1;
                    end else if (conv_ready) begin
                        state_q      <= WAIT;
                        conv_start_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (done_evt) begin
                        m_real_q  <= conv_real;
                        m_imag_q  <= conv_imag;
                        state_q   <= OUT;
                        m_valid_q <= 1'b1;
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        state_q   <= IDLE;
                        m_valid_q <= 1'b0;
                        s_ready_q <= 1'b1;
                        busy_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
`ifdef CONV_SEQ_TIMEOUT_EN
            // Abandon a convolution that stays unanswered too long; this
            // overrides the START->WAIT move made above in the same cycle.
            if ((state_q == START || state_q == WAIT) && !done_evt) begin
                if (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_q      <= IDLE;
                    s_ready_q    <= 1'b1;
                    busy_q       <= 1'b0;
                    conv_start_q <= 1'b0;
                    terr_q       <= 1'b1;
                end else begin
                    tcnt_q <= tcnt_q + 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_conv_sequencer.sv
// Bench for conv_sequencer: transaction-level reference model, a convolver
// agent whose result is x_real times the selected coefficient, directed
// scenarios with literal expectations, then randomized traffic.
module tb_conv_sequencer;

    localparam int DW   = 18;
    localparam int NTAP = 32;
    localparam int TO   = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    reset;
    logic                    s_valid, s_ready;
    logic signed [DW-1:0]    s_real, s_imag, x_real, x_imag;
    logic                    conv_start, conv_ready, conv_done;
    logic signed [DW-1:0]    conv_real, conv_imag;
    logic                    m_valid, m_ready;
    logic signed [DW-1:0]    m_real, m_imag;
    logic                    coef_we;
    logic [4:0]              coef_addr;
    logic signed [DW-1:0]    coef_wr_real, coef_wr_imag;
    logic [NTAP-1:0][DW-1:0] coef_real, coef_imag;
    logic                    busy;
`ifdef CONV_SEQ_TIMEOUT_EN
    logic                    timeout_err;
`endif

    conv_sequencer #(.DW(DW), .NTAP(NTAP), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_real(s_real), .s_imag(s_imag),
        .x_real(x_real), .x_imag(x_imag),
        .conv_start(conv_start), .conv_ready(conv_ready), .conv_done(conv_done),
        .conv_real(conv_real), .conv_imag(conv_imag),
        .m_valid(m_valid), .m_ready(m_ready), .m_real(m_real), .m_imag(m_imag),
        .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_wr_real(coef_wr_real), .coef_wr_imag(coef_wr_imag),
        .coef_real(coef_real), .coef_imag(coef_imag),
        .busy(busy)
`ifdef CONV_SEQ_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    // Reference model: one transaction in flight at most.
    logic [NTAP-1:0][DW-1:0] bank_r, bank_i;
    bit                      have, req, avail, exp_terr, acc_evt;
    logic signed [DW-1:0]    hx_r, hx_i, res_r, res_i;
    int                      tap, tap_next, n_acc, n_out, wait_n;
    // Convolver agent controls.
    int                      rdy_cnt, done_cnt, rdy_next, done_next;
    bit                      rand_dly;

    function automatic logic signed [DW-1:0] mulw(input logic signed [DW-1:0] a,
                                                 input logic signed [DW-1:0] b);
        logic signed [2*DW-1:0] p;
        p = a * b;
        return p[DW-1:0];
    endfunction

    task automatic chk(input string nm, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    task automatic chk_bank(input string nm, input logic [NTAP-1:0][DW-1:0] act,
                            input logic [NTAP-1:0][DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs applied at that edge.
    task automatic model_edge();
        bit fin;
        acc_evt  = 0;
        exp_terr = 0;
        if (reset) begin
            have = 0; req = 0; avail = 0; wait_n = 0;
            bank_r = '0; bank_i = '0;
            hx_r = '0; hx_i = '0; res_r = '0; res_i = '0;
        end else if (!have) begin
            if (coef_we) begin
                bank_r[coef_addr] = coef_wr_real;
                bank_i[coef_addr] = coef_wr_imag;
            end
            if (s_valid) begin
                have = 1; req = 1; acc_evt = 1; n_acc++; wait_n = 0;
                hx_r = s_real; hx_i = s_imag; tap = tap_next;
                if (rand_dly) begin
                    rdy_cnt  = int'($urandom_range(0, 3));
                    done_cnt = int'($urandom_range(0, 5));
                end else begin
                    rdy_cnt  = rdy_next;
                    done_cnt = done_next;
                end
            end
        end else if (!avail) begin
            fin = conv_done && (!req || conv_ready);
            if (fin) begin
                avail = 1; req = 0;
                res_r = mulw(hx_r, bank_r[tap]);
                res_i = mulw(hx_r, bank_i[tap]);
            end else begin
                if (req && conv_ready) req = 0;
`ifdef CONV_SEQ_TIMEOUT_EN
                wait_n++;
                if (wait_n == TO) begin
                    have = 0; req = 0; exp_terr = 1;
                end
`endif
            end
        end else if (m_ready) begin
            have = 0; avail = 0; n_out++;
        end
    endtask

    // Convolver agent: ready after rdy_cnt cycles, done done_cnt cycles later.
    task automatic agent_drive();
        conv_ready = 0;
        conv_done  = 0;
        if (have && req) begin
            if (rdy_cnt == 0) begin
                conv_ready = 1;
                if (done_cnt == 0) conv_done = 1;
                else done_cnt--;
            end else begin
                rdy_cnt--;
            end
        end else if (have && !avail) begin
            if (done_cnt == 0) conv_done = 1;
            else done_cnt--;
        end else begin
            conv_ready = 1'($urandom_range(0, 1));
            conv_done  = 1'($urandom_range(0, 1));
        end
        if (conv_done) begin
            conv_real = mulw(x_real, coef_real[tap]);
            conv_imag = mulw(x_real, coef_imag[tap]);
        end else begin
            conv_real = DW'($urandom);
            conv_imag = DW'($urandom);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        agent_drive();
    endtask

    task automatic wait_mvalid(input string nm, input int lim);
        int n = 0;
        while (m_valid !== 1'b1 && n < lim) begin
            step();
            n++;
        end
        chk(nm, m_valid, 1);
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("s_ready", s_ready, !have);
            chk("busy", busy, have);
            chk("conv_start", conv_start, req);
            chk("m_valid", m_valid, avail);
            chk("m_real", m_real, res_r);
            chk("m_imag", m_imag, res_i);
            chk("x_real", x_real, hx_r);
            chk("x_imag", x_imag, hx_i);
            chk_bank("coef_real", coef_real, bank_r);
            chk_bank("coef_imag", coef_imag, bank_i);
`ifdef CONV_SEQ_TIMEOUT_EN
            chk("timeout_err", timeout_err, exp_terr);
`endif
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ba, bo, guard;
        reset = 1; s_valid = 0; s_real = '0; s_imag = '0; m_ready = 0;
        coef_we = 0; coef_addr = '0; coef_wr_real = '0; coef_wr_imag = '0;
        conv_ready = 0; conv_done = 0; conv_real = '0; conv_imag = '0;
        have = 0; req = 0; avail = 0; exp_terr = 0; acc_evt = 0;
        bank_r = '0; bank_i = '0; hx_r = '0; hx_i = '0; res_r = '0; res_i = '0;
        tap = 0; tap_next = 0; n_acc = 0; n_out = 0; wait_n = 0;
        rdy_cnt = 0; done_cnt = 0; rdy_next = 0; done_next = 0; rand_dly = 0;

        step();
        chk_en = 1;
        step();
        reset = 0;
        chk("rst_s_ready", s_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_x_real", x_real, 0);

        // coef[5]=(100,-7); sample (3,4); done 6 cycles after accept.
        coef_we = 1; coef_addr = 5'd5; coef_wr_real = 18'sd100; coef_wr_imag = -18'sd7;
        step();
        coef_we = 0;
        chk("coef5_real", $signed(coef_real[5]), 100);
        chk("coef5_imag", $signed(coef_imag[5]), -7);
        s_valid = 1; s_real = 18'sd3; s_imag = 18'sd4; tap_next = 5;
        rdy_next = 1; done_next = 4;
        step();
        s_valid = 0;
        wait_mvalid("d1_m_valid", 20);
        chk("d1_m_real", m_real, 300);
        chk("d1_m_imag", m_imag, -21);
        step();
        step();
        chk("d1_m_valid_held", m_valid, 1);
        m_ready = 1;
        step();
        m_ready = 0;
        chk("d1_back_idle", s_ready, 1);

        // Bank write together with accept; ready+done at START entry.
        coef_we = 1; coef_addr = 5'd1; coef_wr_real = -18'sd2; coef_wr_imag = 18'sd5;
        s_valid = 1; s_real = 18'sd7; s_imag = 18'sd9; tap_next = 1;
        rdy_next = 0; done_next = 0;
        step();
        coef_we = 0; s_valid = 0;
        chk("d2_start", conv_start, 1);
        chk("d2_no_mvalid_yet", m_valid, 0);
        step();
        // m_valid is up in the third cycle counting the accept cycle as the first.
        chk("d2_m_valid", m_valid, 1);
        chk("d2_m_real", m_real, -14);
        chk("d2_m_imag", m_imag, 35);
        m_ready = 1;
        step();
        m_ready = 0;

        // Downstream stall with bank writes attempted while busy.
        coef_we = 1; coef_addr = 5'd2; coef_wr_real = 18'sd11; coef_wr_imag = 18'sd12;
        step();
        coef_we = 0;
        s_valid = 1; s_real = -18'sd5; s_imag = 18'sd1; tap_next = 2;
        rdy_next = 0; done_next = 2;
        step();
        s_valid = 0;
        wait_mvalid("d3_m_valid", 20);
        for (int i = 0; i < 10; i++) begin
            coef_we = 1; coef_addr = 5'd2; coef_wr_real = 18'sd999; coef_wr_imag = 18'sd999;
            step();
        end
        coef_we = 0;
        chk("d3_m_valid_stall", m_valid, 1);
        chk("d3_m_real_stall", m_real, -55);
        chk("d3_m_imag_stall", m_imag, -60);
        chk("d3_s_ready_stall", s_ready, 0);
        chk("d3_coef2_kept", $signed(coef_real[2]), 11);
        m_ready = 1;
        step();
        m_ready = 0;

        // Reset while waiting for conv_done.
        s_valid = 1; s_real = 18'sd6; s_imag = 18'sd6; tap_next = 5;
        rdy_next = 0; done_next = 50;
        step();
        s_valid = 0;
        step();
        step();
        chk("d4_in_wait_busy", busy, 1);
        reset = 1;
        step();
        reset = 0;
        chk("d4_conv_start", conv_start, 0);
        chk("d4_m_valid", m_valid, 0);
        chk("d4_s_ready", s_ready, 1);
        chk_bank("d4_coef_zero", coef_real | coef_imag, '0);

`ifdef CONV_SEQ_TIMEOUT_EN
        // Convolver never finishes.
        s_valid = 1; s_real = 18'sd1; s_imag = 18'sd1; tap_next = 0;
        rdy_next = 2; done_next = 100000;
        step();
        s_valid = 0;
        guard = 0;
        while (timeout_err !== 1'b1 && guard < TO + 16) begin
            step();
            guard++;
        end
        chk("to_pulse", timeout_err, 1);
        chk("to_s_ready", s_ready, 1);
        chk("to_m_valid", m_valid, 0);
        step();
        chk("to_pulse_one_cycle", timeout_err, 0);
`endif

        // Four back-to-back samples with s_valid held high.
        rand_dly = 1;
        ba = n_acc; bo = n_out; guard = 0;
        m_ready = 1; s_valid = 1;
        s_real = DW'($urandom); s_imag = DW'($urandom); tap_next = int'($urandom_range(0, 7));
        while ((n_out - bo) < 4 && guard < 200) begin
            step();
            guard++;
            if (acc_evt) begin
                if (n_acc - ba >= 4) s_valid = 0;
                else begin
                    s_real = DW'($urandom); s_imag = DW'($urandom);
                    tap_next = int'($urandom_range(0, 7));
                end
            end
        end
        s_valid = 0; m_ready = 0;
        chk("b2b_results", n_out - bo, 4);
        chk("b2b_accepts", n_acc - ba, 4);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 2500; c++) begin
            step();
            reset        = ($urandom_range(0, 399) == 0);
            s_valid      = ($urandom_range(0, 2) != 0);
            s_real       = DW'($urandom);
            s_imag       = DW'($urandom);
            m_ready      = 1'($urandom_range(0, 1));
            coef_we      = ($urandom_range(0, 3) == 0);
            coef_addr    = 5'($urandom_range(0, 7));
            coef_wr_real = DW'($urandom);
            coef_wr_imag = DW'($urandom);
            tap_next     = int'($urandom_range(0, 7));
        end
        reset = 0; s_valid = 0; coef_we = 0; m_ready = 1;
        for (int c = 0; c < 20; c++) step();
        chk("rand_traffic_seen", (n_acc > 100), 1);

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_sequencer.md
CONV_SEQUENCER -- requirements
Module: conv_sequencer

Interface
REQ-001 SHALL have parameter: DW, 18, sample/coefficient width (signed two's complement).
REQ-002 SHALL have parameter: NTAP, 32, coefficient bank depth.
REQ-003 SHALL have parameter: TIMEOUT_CYCLES, 64, max WAIT cycles before abort (used only under REQ-027).
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk, reset.
REQ-005 SHALL have ports: clk  in  1  clock; reset  in  1  sync active-high reset.
REQ-006 SHALL have ports: s_valid in 1, s_ready out 1, s_real in DW, s_imag in DW  input sample stream.
REQ-007 SHALL have ports: x_real out DW, x_imag out DW  held sample to convolver x_in.
REQ-008 SHALL have ports: conv_start out 1, conv_ready in 1, conv_done in 1  convolver ap_ctrl_hs handshake.
REQ-009 SHALL have ports: conv_real in DW, conv_imag in DW  convolver result.
REQ-010 SHALL have ports: m_valid out 1, m_ready in 1, m_real out DW, m_imag out DW  result stream.
REQ-011 SHALL have ports: coef_we in 1, coef_addr in 5, coef_wr_real in DW, coef_wr_imag in DW  bank write.
REQ-012 SHALL have ports: coef_real out NTAP*DW, coef_imag out NTAP*DW  packed [NTAP-1:0][DW-1:0] bank to convolver.
REQ-013 SHALL have port: busy out 1  high whenever state != IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, START, WAIT, OUT.
REQ-015 SHALL assert s_ready only in IDLE; s_valid&s_ready loads x_real/x_imag and moves to START next cycle.
REQ-016 SHALL hold x_real/x_imag constant from load until return to IDLE.
REQ-017 SHALL assert conv_start throughout START; conv_ready=1 in START moves to WAIT (conv_start low next cycle).
REQ-018 SHALL, when conv_ready and conv_done both 1 in START, capture conv_real/conv_imag and go directly to OUT.
REQ-019 SHALL, in WAIT, on conv_done=1 register conv_real/conv_imag into m_real/m_imag and go to OUT.
REQ-020 SHALL assert m_valid only in OUT with m_real/m_imag stable; m_ready=1 returns to IDLE next cycle.
REQ-021 SHALL give minimum latency of 3 cycles from input accept to m_valid (conv_ready and conv_done same cycle as START entry).
REQ-022 SHALL write coef bank entry coef_addr with coef_wr_real/imag when coef_we=1 and state=IDLE; writes outside IDLE are ignored.
REQ-023 SHALL, on coef_we and s_valid accepted in the same IDLE cycle, apply the write before the new sample's START.
REQ-024 SHALL pass all data unmodified (no rounding, saturation, or width change).

Reset
REQ-025 SHALL on reset: state IDLE, s_ready=1 next cycle, conv_start=0, m_valid=0, busy=0, x_*=0, m_*=0, all coef entries 0.
REQ-026 SHALL on reset mid-transaction discard the pending sample and result; reset dominates all other inputs.

Configuration
REQ-027 SHALL, with CONV_SEQ_TIMEOUT_EN defined, add output timeout_err (1 bit) and a WAIT/START cycle counter; if conv_done not seen within TIMEOUT_CYCLES, return to IDLE, drop conv_start, pulse timeout_err one cycle, emit no m_valid.
REQ-028 SHALL, without CONV_SEQ_TIMEOUT_EN, have no timeout_err port and wait indefinitely in START/WAIT.

Verification
REQ-029 SHALL cover: load coef[5]=(100,-7), then s=(3,4), conv done after 6 cycles with (300,-21) -> m=(300,-21) m_valid until m_ready, coef_real[5]=100.
REQ-030 SHALL cover: conv_ready and conv_done high same cycle as START -> m_valid exactly 3 cycles after accept.
REQ-031 SHALL cover: m_ready held low 10 cycles -> m_valid/m_real stable, s_ready=0, coef_we to addr 2 ignored (coef_real[2] unchanged).
REQ-032 SHALL cover: reset asserted in WAIT -> next cycle conv_start=0, m_valid=0, s_ready=1, all coefs 0.
REQ-033 SHALL cover (timeout build): conv_done never asserted, TIMEOUT_CYCLES=64 -> timeout_err one-cycle pulse, s_ready=1, no m_valid.
REQ-034 SHALL cover: back-to-back 4 samples with s_valid constant -> 4 results in order, no sample accepted while busy.
